// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with single-cycle expiry pulse.
//
// A period is accepted over a valid/ready load port while idle, counted down to zero,
// and a one-cycle done pulse is emitted at terminal count. In auto-reload mode the
// stored period is reloaded at terminal count and counting continues. A running count
// can be held with pause_i or cancelled with abort_i (abort wins over pause).
//
// Ports:
//   clk_i        clock, all logic on posedge
//   rst_i        synchronous active-high reset
//   s_valid_i    load request
//   s_ready_o    load accept (combinational: idle and not in reset)
//   s_data_i     period to load, in cycles; zero gives an immediate expiry
//   reload_en_i  auto-reload at terminal count, sampled in the terminal cycle
//   pause_i      hold the count this cycle (running only)
//   abort_i      cancel a running count (running only)
//   count_o      live remaining count
//   busy_o       high while counting
//   done_o       one-cycle expiry pulse
//   expiries_o   number of done pulses since reset, wrapping
module countdown_timer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EXP_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [WIDTH-1:0]     s_data_i,
  input  logic                 reload_en_i,
  input  logic                 pause_i,
  input  logic                 abort_i,
  output logic [WIDTH-1:0]     count_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [EXP_WIDTH-1:0] expiries_o
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [WIDTH-1:0]     period_q, period_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [EXP_WIDTH-1:0] expiries_q, expiries_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (s_valid_i) begin
          period_d = s_data_i;
          count_d  = s_data_i;
          if (s_data_i != '0) begin
            state_d = StRun;
            busy_d  = 1'b1;
          end else begin
            // Zero-length period expires at once without entering RUN.
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (abort_i) begin
          state_d = StIdle;
          count_d = '0;
          busy_d  = 1'b0;
        end else if (pause_i) begin
          // Hold everything, including at terminal count.
        end else if (count_q > WIDTH'(1)) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          // Terminal count; RUN is only entered with a non-zero count, so this is count==1.
          done_d = 1'b1;
          if (reload_en_i) begin
            count_d = period_q;
          end else begin
            state_d = StIdle;
            count_d = '0;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
        busy_d  = 1'b0;
      end
    endcase

    // Counted alongside the registered pulse so expiries_o includes a visible done_o.
    expiries_d = expiries_q + {{(EXP_WIDTH-1){1'b0}}, done_d};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      count_q    <= '0;
      period_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      expiries_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      period_q   <= period_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      expiries_q <= expiries_d;
    end
  end

  assign s_ready_o  = !rst_i && (state_q == StIdle);
  assign count_o    = count_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign expiries_o = expiries_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a reference model steps on each clock edge and
// queues the expected outputs; a monitor on the falling edge pops and compares them.
module tb_countdown_timer;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        reload_en;
  logic        pause;
  logic        abort;
  logic [7:0]  count;
  logic        busy;
  logic        done;
  logic [15:0] expiries;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  countdown_timer #(
    .WIDTH    (8),
    .EXP_WIDTH(16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .s_valid_i  (s_valid),
    .s_ready_o  (s_ready),
    .s_data_i   (s_data),
    .reload_en_i(reload_en),
    .pause_i    (pause),
    .abort_i    (abort),
    .count_o    (count),
    .busy_o     (busy),
    .done_o     (done),
    .expiries_o (expiries)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model: tracks elapsed cycles of the current period rather than a live count.
  typedef struct {
    int count;
    bit busy;
    bit done;
    int exp;
    bit idle;
  } exp_t;

  exp_t sb_q[$];
  bit   m_run     = 0;
  int   m_period  = 0;
  int   m_elapsed = 0;
  int   m_total   = 0;

  task automatic model_step();
    exp_t e;
    bit   d;
    d = 0;
    if (rst) begin
      m_run = 0; m_period = 0; m_elapsed = 0; m_total = 0;
    end else if (!m_run) begin
      if (s_valid) begin
        m_period  = int'(s_data);
        m_elapsed = 0;
        if (m_period == 0) d = 1;
        else m_run = 1;
      end
    end else if (abort) begin
      m_run = 0;
    end else if (!pause) begin
      m_elapsed++;
      if (m_elapsed == m_period) begin
        d = 1;
        if (reload_en) m_elapsed = 0;
        else m_run = 0;
      end
    end
    if (d) m_total++;
    e.count = m_run ? (m_period - m_elapsed) : 0;
    e.busy  = m_run;
    e.done  = d;
    e.exp   = m_total % 65536;
    e.idle  = !m_run;
    sb_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    cycle++;
    model_step();
  end

  // Monitor
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      if (cycle > 0) chk("sb_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk("count", int'(count), e.count);
      chk("busy", int'(busy), int'(e.busy));
      chk("done", int'(done), int'(e.done));
      chk("expiries", int'(expiries), e.exp);
      chk("s_ready", int'(s_ready), int'(!rst && e.idle));
    end
  end

  task automatic cyc(input logic sv, input logic [7:0] d, input logic rl, input logic pa,
                     input logic ab, input logic r);
    s_valid   = sv;
    s_data    = d;
    reload_en = rl;
    pause     = pa;
    abort     = ab;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rl);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, rl, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int lat;
    s_valid = 1'b1; s_data = 8'd7; reload_en = 1'b0; pause = 1'b0; abort = 1'b0; rst = 1'b1;
    // Reset with a pending load that must be ignored.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_count", int'(count), 0);
    chk("reset_ready", int'(s_ready), 0);

    // One-shot of 5.
    cyc(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_load_count", int'(count), 5);
    idle(6, 1'b0);
    chk("t1_expiries", int'(expiries), 1);

    // Pause at count 2.
    cyc(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_paused_count", int'(count), 2);
    idle(4, 1'b0);

    // Auto-reload of 4, then drop reload.
    cyc(1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(11, 1'b1);
    idle(6, 1'b0);
    chk("t3_idle_ready", int'(s_ready), 1);

    // Zero-length load.
    cyc(1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_done", int'(done), 1);
    idle(2, 1'b0);

    // Abort together with pause at count 2, then reset mid-run at count 3.
    cyc(1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t5_abort_count", int'(count), 0);
    idle(2, 1'b0);
    cyc(1'b1, 8'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    cyc(1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5_reset_busy", int'(busy), 0);
    idle(2, 1'b0);

    // Full-range load: done exactly 255 edges after the load edge.
    cyc(1'b1, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);
    lat = -1;
    for (int i = 1; i <= 400; i++) begin
      idle(1, 1'b0);
      if (done && lat < 0) begin
        lat = i;
        break;
      end
    end
    chk("t6_latency", lat, 255);
    idle(2, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
      cyc(1'($urandom_range(0, 2) == 0), d, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 19) == 0),
          1'($urandom_range(0, 99) == 0));
    end

    // Expiry counter wrap: back-to-back zero loads give one done per cycle.
    cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 65535; i++) cyc(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_max", int'(expiries), 65535);
    cyc(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wrap_zero", int'(expiries), 0);
    chk("wrap_done", int'(done), 1);
    idle(3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
